// File: rtl/letreiro_sequenciador.sv
// Letter-code sequencer for the 7-segment letter decoder.
// Plays U-F-E-R-S-A with a programmable per-letter hold, pause/resume, loop or single-shot.
`timescale 1ns/1ps
module letreiro_sequenciador #(
   parameter int TICK_DIV = 50000000,
   parameter int MSG_LEN  = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       loop,
   output logic [2:0] codigo,
   output logic [2:0] indice,
   output logic       ativo,
   output logic       fim
);
   localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [2:0]     IDX_MAX = 3'(MSG_LEN - 1);
   localparam logic [2:0]     BLANK   = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t          st, st_nx;
   logic [PW-1:0]   pre, pre_nx;
   logic [2:0]      idx_nx, cod_nx;
   logic            ativo_nx, fim_nx;

   function automatic logic [2:0] letra(input logic [2:0] i);
      case (i)
         3'd0:    return 3'b000; // U
         3'd1:    return 3'b001; // F
         3'd2:    return 3'b010; // E
         3'd3:    return 3'b011; // R
         3'd4:    return 3'b100; // S
         3'd5:    return 3'b101; // A
         default: return BLANK;
      endcase
   endfunction

   always_comb begin
      st_nx  = st;
      pre_nx = pre;
      idx_nx = indice;
      cod_nx = codigo;
      case (st)
         IDLE: begin
            cod_nx = BLANK;
            if (start) begin
               st_nx  = RUN;
               pre_nx = '0;
               idx_nx = '0;
               cod_nx = letra(3'd0);
            end
         end
         RUN: begin
            if (start) begin
               pre_nx = '0;
               idx_nx = '0;
               cod_nx = letra(3'd0);
            end else if (pause) begin
               st_nx = PAUSE;
            end else if (pre == PRE_MAX) begin
               pre_nx = '0;
               if (indice < IDX_MAX) begin
                  idx_nx = indice + 3'd1;
                  cod_nx = letra(indice + 3'd1);
               end else if (loop) begin
                  idx_nx = '0;
                  cod_nx = letra(3'd0);
               end else begin
                  st_nx  = DONE;
                  idx_nx = '0;
                  cod_nx = BLANK;
               end
            end else begin
               pre_nx = pre + PW'(1);
            end
         end
         PAUSE: begin
            // resume keeps the frozen prescaler so the remaining hold time survives the pause
            if (start) begin
               st_nx  = RUN;
               pre_nx = '0;
               idx_nx = '0;
               cod_nx = letra(3'd0);
            end else if (!pause) begin
               st_nx = RUN;
            end
         end
         DONE: begin
            st_nx  = IDLE;
            cod_nx = BLANK;
         end
         default: begin
            st_nx  = IDLE;
            pre_nx = '0;
            idx_nx = '0;
            cod_nx = BLANK;
         end
      endcase
      ativo_nx = (st_nx == RUN) || (st_nx == PAUSE);
      fim_nx   = (st_nx == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= IDLE;
         pre    <= '0;
         indice <= '0;
         codigo <= BLANK;
         ativo  <= 1'b0;
         fim    <= 1'b0;
      end else begin
         st     <= st_nx;
         pre    <= pre_nx;
         indice <= idx_nx;
         codigo <= cod_nx;
         ativo  <= ativo_nx;
         fim    <= fim_nx;
      end
   end
endmodule

// File: tb/tb_letreiro_sequenciador.sv
// Scoreboard bench: a hold-countdown model of the sequencer predicts every cycle for
// a 6-letter and a 1-letter instance driven with the same controls.
`timescale 1ns/1ps
module tb_letreiro_sequenciador;
   localparam int TICK = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, pause = 1'b0, loop = 1'b0;
   logic [2:0] cod [2];
   logic [2:0] idx [2];
   logic       atv [2];
   logic       fm  [2];

   int n_chk = 0, n_fail = 0;
   int act_cnt = 0, fim_cnt = 0;

   typedef struct {int cod; int idx; int atv; int fim; int chk_idx;} exp_t;
   exp_t sb[$];

   // model: 0 idle, 1 run, 2 pause, 3 done; rem = cycles left on current letter
   int m_st[2], m_idx[2], m_rem[2];
   int m_len[2] = '{6, 1};

   always #5 clk = ~clk;

   letreiro_sequenciador #(.TICK_DIV(TICK), .MSG_LEN(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .loop(loop),
      .codigo(cod[0]), .indice(idx[0]), .ativo(atv[0]), .fim(fm[0]));

   letreiro_sequenciador #(.TICK_DIV(TICK), .MSG_LEN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .loop(loop),
      .codigo(cod[1]), .indice(idx[1]), .ativo(atv[1]), .fim(fm[1]));

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_idx[k] = 0; m_rem[k] = TICK;
      end
   endtask

   task automatic model_step(input int k, input logic s, input logic p, input logic l);
      case (m_st[k])
         0: if (s) begin m_st[k] = 1; m_idx[k] = 0; m_rem[k] = TICK; end
         1: begin
            if (s) begin
               m_idx[k] = 0; m_rem[k] = TICK;
            end else if (p) begin
               m_st[k] = 2;
            end else if (m_rem[k] == 1) begin
               m_rem[k] = TICK;
               if (m_idx[k] < m_len[k] - 1) m_idx[k]++;
               else if (l) m_idx[k] = 0;
               else begin m_st[k] = 3; m_idx[k] = 0; end
            end else begin
               m_rem[k]--;
            end
         end
         2: begin
            if (s) begin m_st[k] = 1; m_idx[k] = 0; m_rem[k] = TICK; end
            else if (!p) m_st[k] = 1;
         end
         default: m_st[k] = 0;
      endcase
   endtask

   task automatic cyc(input logic s, input logic p, input logic l);
      exp_t e;
      @(negedge clk);
      start = s; pause = p; loop = l;
      for (int k = 0; k < 2; k++) begin
         model_step(k, s, p, l);
         e.atv     = (m_st[k] == 1 || m_st[k] == 2) ? 1 : 0;
         e.fim     = (m_st[k] == 3) ? 1 : 0;
         e.idx     = m_idx[k];
         e.cod     = e.atv ? m_idx[k] : 7;
         e.chk_idx = e.atv;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = sb.pop_front();
         chk($sformatf("codigo[%0d]", k), int'(cod[k]), e.cod);
         chk($sformatf("ativo[%0d]", k), int'(atv[k]), e.atv);
         chk($sformatf("fim[%0d]", k), int'(fm[k]), e.fim);
         if (e.chk_idx != 0) chk($sformatf("indice[%0d]", k), int'(idx[k]), e.idx);
      end
      if (cod[0] != 3'b111) act_cnt++;
      if (fm[0]) fim_cnt++;
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_codigo[%0d]", tag, k), int'(cod[k]), 7);
         chk($sformatf("%s_indice[%0d]", tag, k), int'(idx[k]), 0);
         chk($sformatf("%s_ativo[%0d]", tag, k), int'(atv[k]), 0);
         chk($sformatf("%s_fim[%0d]", tag, k), int'(fm[k]), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // single-shot playback; pause while idle must do nothing
      cyc(0, 1, 0); cyc(0, 0, 0);
      act_cnt = 0; fim_cnt = 0;
      cyc(1, 0, 0);
      for (int i = 0; i < 28; i++) cyc(0, 0, 0);
      chk("active_cycles", act_cnt, 24);
      chk("fim_pulses", fim_cnt, 1);

      // looping playback, then restart while R is shown
      fim_cnt = 0;
      cyc(1, 0, 1);
      for (int i = 0; i < 30; i++) cyc(0, 0, 1);
      for (int i = 0; i < 40 && !(m_st[0] == 1 && m_idx[0] == 3); i++) cyc(0, 0, 1);
      chk("reach_R", int'(idx[0]), 3);
      cyc(1, 0, 1);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);
      chk("loop_no_fim", fim_cnt, 0);

      // start together with pause restarts into RUN
      cyc(1, 1, 1);
      cyc(0, 0, 1);

      // pause two counted cycles into F for 10 cycles
      cyc(1, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1);
      chk("on_F", int'(cod[0]), 1);
      cyc(0, 0, 1); cyc(0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(0, 1, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1);
      chk("after_pause_E", int'(cod[0]), 2);

      // drop loop, let it finish, start during DONE is ignored, then taken in IDLE
      for (int i = 0; i < 40 && m_st[0] != 3; i++) cyc(0, 0, 0);
      chk("reach_done", int'(fm[0]), 1);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0);

      // asynchronous reset in the middle of S
      cyc(1, 0, 0);
      for (int i = 0; i < 18; i++) cyc(0, 0, 0);
      chk("on_S", int'(cod[0]), 4);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
